// File: rtl/singly_linked_list_traverser.sv
// singly_linked_list_traverser
//   Walks a singly linked list from head to tail after a one-cycle start
//   request. For each node it issues a Read (op 0) on the list command port,
//   follows the returned next pointer and streams the node data on a
//   valid/ready output. The final beat is flagged with m_last_o.
//
// Optional feature (macro SINGLY_LINKED_LIST_TRAVERSER_CYCLE_CHECK_EN):
//   bounds the walk at the length snapshotted at start, so a cyclic or
//   over-long list ends with err_o=1.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              begin a traversal (ignored while busy_o)
//   busy_o, done_o       traversal in progress / one-cycle end pulse
//   err_o                traversal ended abnormally (valid with done_o)
//   count_o              beats emitted by the last traversal
//   ll_op_o .. ll_addr_o list command port (read only)
//   ll_op_done_i ..      list response and status
//   m_valid_o .. m_last_o output beat stream, m_ready_i backpressure
module singly_linked_list_traverser #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_NODE   = 8,
    localparam int unsigned ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] count_o,
    output logic [2:0]            ll_op_o,
    output logic                  ll_op_start_o,
    output logic [ADDR_WIDTH-1:0] ll_addr_o,
    input  logic                  ll_op_done_i,
    input  logic                  ll_fault_i,
    input  logic [DATA_WIDTH-1:0] ll_data_out_i,
    input  logic [ADDR_WIDTH-1:0] ll_next_node_addr_i,
    input  logic [ADDR_WIDTH-1:0] ll_head_i,
    input  logic [ADDR_WIDTH-1:0] ll_length_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic                  m_last_o
);

    localparam logic [ADDR_WIDTH-1:0] AddrNull = ADDR_WIDTH'(MAX_NODE + 1);
    localparam logic [ADDR_WIDTH-1:0] AddrMax  = ADDR_WIDTH'(MAX_NODE);

    typedef enum logic [1:0] {StIdle, StIssue, StEmit, StFinish} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, nxt_q, count_q, m_addr_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    last_q, err_q;

    logic start_ok, empty, capture, fault, handshake;
    logic corrupt, last_d, err_sched;

    assign start_ok  = (state_q == StIdle) && start_i;
    assign empty     = (ll_length_i == '0) || (ll_head_i == AddrNull);
    assign capture   = (state_q == StIssue) && ll_op_done_i && !ll_fault_i;
    assign fault     = (state_q == StIssue) && ll_op_done_i && ll_fault_i;
    assign handshake = (state_q == StEmit) && m_ready_i;

`ifdef SINGLY_LINKED_LIST_TRAVERSER_CYCLE_CHECK_EN
    logic [ADDR_WIDTH-1:0] k_q, len_snap_q, k_inc;
    assign k_inc = k_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q        <= '0;
            len_snap_q <= '0;
        end else if (start_ok) begin
            k_q        <= '0;
            len_snap_q <= ll_length_i;
        end else if (capture) begin
            k_q        <= k_inc;
        end
    end
`endif

    // Last-beat decision is taken when the read returns, so EMIT only waits.
    always_comb begin
        corrupt   = (ll_next_node_addr_i != AddrNull) && (ll_next_node_addr_i >= AddrMax);
        last_d    = (ll_next_node_addr_i == AddrNull) || corrupt;
        err_sched = corrupt;
`ifdef SINGLY_LINKED_LIST_TRAVERSER_CYCLE_CHECK_EN
        // k_inc counts the node being captured now.
        if ((k_inc == len_snap_q) && (ll_next_node_addr_i != AddrNull)) begin
            last_d    = 1'b1;
            err_sched = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = empty ? StFinish : StIssue;
            StIssue:  if (ll_op_done_i) state_d = ll_fault_i ? StFinish : StEmit;
            StEmit:   if (m_ready_i) state_d = last_q ? StFinish : StIssue;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_addr_q <= AddrNull;
            nxt_q      <= AddrNull;
            count_q    <= '0;
            m_addr_q   <= AddrNull;
            m_data_q   <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (start_ok) begin
                cur_addr_q <= ll_head_i;
                count_q    <= '0;
                err_q      <= 1'b0;
            end
            if (fault) err_q <= 1'b1;
            if (capture) begin
                m_data_q <= ll_data_out_i;
                m_addr_q <= cur_addr_q;
                nxt_q    <= ll_next_node_addr_i;
                last_q   <= last_d;
                err_q    <= err_sched;
            end
            if (handshake) begin
                count_q <= count_q + ADDR_WIDTH'(1);
                if (!last_q) cur_addr_q <= nxt_q;
            end
        end
    end

    // Outputs
    always_comb begin
        busy_o        = (state_q != StIdle);
        done_o        = (state_q == StFinish);
        err_o         = (state_q == StFinish) && err_q;
        count_o       = count_q;
        ll_op_o       = 3'd0;
        ll_op_start_o = (state_q == StIssue);
        ll_addr_o     = cur_addr_q;
        m_valid_o     = (state_q == StEmit);
        m_data_o      = m_data_q;
        m_addr_o      = m_addr_q;
        m_last_o      = (state_q == StEmit) && last_q;
    end

endmodule

// File: tb/tb_singly_linked_list_traverser.sv
module tb_singly_linked_list_traverser;

    localparam int DW   = 8;
    localparam int MAXN = 8;
    localparam int AW   = 4;
    localparam int NUL  = MAXN + 1;

`ifdef SINGLY_LINKED_LIST_TRAVERSER_CYCLE_CHECK_EN
    localparam bit CycEn = 1'b1;
`else
    localparam bit CycEn = 1'b0;
`endif

    logic          clk, rst_n, start, busy, done, err;
    logic [AW-1:0] count, ll_addr, ll_next, ll_head, ll_length, m_addr;
    logic [2:0]    ll_op;
    logic          ll_op_start, ll_op_done, ll_fault, m_valid, m_ready, m_last;
    logic [DW-1:0] ll_data, m_data;

    singly_linked_list_traverser #(.DATA_WIDTH(DW), .MAX_NODE(MAXN)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .err_o(err), .count_o(count), .ll_op_o(ll_op), .ll_op_start_o(ll_op_start),
        .ll_addr_o(ll_addr), .ll_op_done_i(ll_op_done), .ll_fault_i(ll_fault),
        .ll_data_out_i(ll_data), .ll_next_node_addr_i(ll_next), .ll_head_i(ll_head),
        .ll_length_i(ll_length), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_data_o(m_data), .m_addr_o(m_addr), .m_last_o(m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural list contents
    int node_data [MAXN];
    int node_next [MAXN];
    int head_v, len_v, fault_idx;
    int rd_cnt  = 0;
    int rd_base = 0;

    // List responder: completes each read one cycle after the request rises.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ll_op_done <= 1'b0;
            ll_fault   <= 1'b0;
            ll_data    <= '0;
            ll_next    <= AW'(NUL);
        end else if (ll_op_start && !ll_op_done) begin
            ll_op_done <= 1'b1;
            ll_fault   <= (rd_cnt - rd_base + 1 == fault_idx);
            rd_cnt     <= rd_cnt + 1;
            ll_data    <= (ll_addr < MAXN) ? DW'(node_data[ll_addr[2:0]]) : '0;
            ll_next    <= (ll_addr < MAXN) ? AW'(node_next[ll_addr[2:0]]) : AW'(NUL);
        end else begin
            ll_op_done <= 1'b0;
            ll_fault   <= 1'b0;
        end
    end

    // Ready generator: 0 always ready, 1 random, 2 five stall cycles per beat
    int rdy_mode = 0;
    int stall    = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                if (!m_valid) begin
                    m_ready = 1'b0;
                    stall   = 0;
                end else if (stall < 5) begin
                    m_ready = 1'b0;
                    stall++;
                end else begin
                    m_ready = 1'b1;
                    stall   = 0;
                end
            end
        endcase
    end

    // Reference model: expected beats and end status from the list contents
    int exp_data[$];
    int exp_addr[$];
    int exp_last[$];
    int exp_err, exp_count, exp_lat;

    task automatic build_expect();
        int a, k, reads, nx, lst;
        bit stop, faulted;
        exp_data.delete();
        exp_addr.delete();
        exp_last.delete();
        exp_err = 0;
        a = head_v; k = 0; reads = 0; faulted = 0;
        stop = (len_v == 0) || (head_v == NUL);
        while (!stop && reads < 64) begin
            reads++;
            if (reads == fault_idx) begin
                exp_err = 1; faulted = 1; stop = 1;
            end else begin
                nx = node_next[a];
                k++;
                lst = 0;
                if (nx == NUL) lst = 1;
                else if (nx >= MAXN) begin lst = 1; exp_err = 1; end
                else if (CycEn && k == len_v) begin lst = 1; exp_err = 1; end
                exp_data.push_back(node_data[a]);
                exp_addr.push_back(a);
                exp_last.push_back(lst);
                if (lst != 0) stop = 1;
                else a = nx;
            end
        end
        exp_count = k;
        if ((len_v == 0) || (head_v == NUL)) exp_lat = 1;
        else if (faulted) exp_lat = 3 * k + 3;
        else exp_lat = 3 * k + 1;
    endtask

    // Single compare process
    int done_cnt   = 0;
    int beats_seen = 0;
    int seen_count, seen_lat;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ll_op", 32'(ll_op), 0);
            if (cyc == t0 + 1) chk("busy_cycle1", 32'(busy), 1);
            if (m_valid) begin
                chk("no_read_in_emit", 32'(ll_op_start), 0);
                if (exp_data.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %0h addr %0h, expected no beat",
                             m_data, m_addr);
                end else begin
                    chk("m_data", 32'(m_data), 32'(exp_data[0]));
                    chk("m_addr", 32'(m_addr), 32'(exp_addr[0]));
                    chk("m_last", 32'(m_last), 32'(exp_last[0]));
                    if (m_ready) begin
                        void'(exp_data.pop_front());
                        void'(exp_addr.pop_front());
                        void'(exp_last.pop_front());
                        beats_seen++;
                    end
                end
            end
            if (done) begin
                chk("done_err", 32'(err), 32'(exp_err));
                chk("done_count", 32'(count), 32'(exp_count));
                chk("beats_missing", 32'(exp_data.size()), 0);
                if (exp_lat >= 0) chk("done_cycle", 32'(cyc - t0), 32'(exp_lat));
                seen_count = int'(count);
                seen_lat   = cyc - t0;
                done_cnt++;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_ll_op_start"}, 32'(ll_op_start), 0);
        chk({tag, "_ll_addr"}, 32'(ll_addr), NUL);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_data"}, 32'(m_data), 0);
        chk({tag, "_m_addr"}, 32'(m_addr), NUL);
        chk({tag, "_m_last"}, 32'(m_last), 0);
    endtask

    task automatic set_list(input int h, input int l);
        head_v    = h;
        len_v     = l;
        ll_head   = AW'(h);
        ll_length = AW'(l);
    endtask

    task automatic three_node_list();
        for (int i = 0; i < MAXN; i++) begin node_data[i] = 0; node_next[i] = NUL; end
        node_data[0] = 'hA1; node_next[0] = 1;
        node_data[1] = 'hB2; node_next[1] = 2;
        node_data[2] = 'hC3; node_next[2] = NUL;
        set_list(0, 3);
    endtask

    task automatic run(input bit spam);
        int d0, n;
        build_expect();
        if (rdy_mode != 0) exp_lat = -1;
        d0 = done_cnt;
        @(posedge clk); #1;
        rd_base = rd_cnt;
        t0 = cyc;
        start = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 600) begin
            @(posedge clk); #1;
            n++;
            start = spam && busy && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
            exp_data.delete(); exp_addr.delete(); exp_last.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int perm[MAXN];
        int l, tmp, j, b0;
        start = 0; m_ready = 0; fault_idx = 0;
        three_node_list();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #10 check_reset_vals("reset");
        @(negedge clk); rst_n = 1'b1;

        // Empty list
        for (int i = 0; i < MAXN; i++) begin node_data[i] = 0; node_next[i] = NUL; end
        set_list(NUL, 0);
        rdy_mode = 0;
        run(0);
        chk("empty_lat_lit", 32'(seen_lat), 1);
        chk("empty_count_lit", 32'(seen_count), 0);

        // Three-node list, model pinned to hand-computed values
        three_node_list();
        build_expect();
        chk("pin_model_beats", 32'(exp_data.size()), 3);
        chk("pin_model_c3", 32'(exp_data[2]), 'hC3);
        chk("pin_model_last_b2", 32'(exp_last[1]), 0);
        chk("pin_model_last_c3", 32'(exp_last[2]), 1);
        run(0);
        chk("three_lat_lit", 32'(seen_lat), 10);
        chk("three_count_lit", 32'(seen_count), 3);

        // Backpressure
        rdy_mode = 2;
        run(0);
        chk("bp_count_lit", 32'(seen_count), 3);

        // Fault on the second read
        rdy_mode = 0;
        fault_idx = 2;
        build_expect();
        chk("pin_fault_beats", 32'(exp_data.size()), 1);
        chk("pin_fault_err", 32'(exp_err), 1);
        run(0);
        chk("fault_count_lit", 32'(seen_count), 1);
        fault_idx = 0;

`ifdef SINGLY_LINKED_LIST_TRAVERSER_CYCLE_CHECK_EN
        // Two nodes, tail links back to head
        for (int i = 0; i < MAXN; i++) begin node_data[i] = 0; node_next[i] = NUL; end
        node_data[2] = 'h11; node_next[2] = 5;
        node_data[5] = 'h22; node_next[5] = 2;
        set_list(2, 2);
        build_expect();
        chk("pin_cyc_beats", 32'(exp_data.size()), 2);
        chk("pin_cyc_err", 32'(exp_err), 1);
        run(0);
        chk("cyc_count_lit", 32'(seen_count), 2);
`endif

        // Reset during the second EMIT, then walk again from the head
        three_node_list();
        build_expect();
        b0 = beats_seen;
        @(posedge clk); #1;
        rd_base = rd_cnt; t0 = cyc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (m_valid && beats_seen == b0 + 1) break;
        end
        chk("rst_mid_in_emit", 32'(m_valid), 1);
        rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        exp_data.delete(); exp_addr.delete(); exp_last.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run(0);
        chk("rst_rerun_count_lit", 32'(seen_count), 3);

        // Randomized lists
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < MAXN; i++) begin
                perm[i] = i;
                node_data[i] = $urandom_range(0, 255);
                node_next[i] = NUL;
            end
            for (int i = MAXN - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            l = $urandom_range(0, MAXN);
            for (int i = 0; i + 1 < l; i++) node_next[perm[i]] = perm[i + 1];
            if (l > 0 && $urandom_range(0, 5) == 0)
                node_next[perm[l - 1]] = ($urandom_range(0, 1) != 0) ? MAXN
                                                                     : $urandom_range(10, 15);
            if (l == 0) set_list(($urandom_range(0, 1) != 0) ? NUL : perm[0], 0);
            else if ($urandom_range(0, 9) == 0) set_list(NUL, l);
            else set_list(perm[0], l);
            fault_idx = (l > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, l) : 0;
            rdy_mode = $urandom_range(0, 2);
            run(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
